rv32_multicycle_seq: RTL and testbench

- Multicycle sequencer for the RV32I core.
- Fetches an instruction over a req/ready instruction-memory port and latches it into the instruction register feeding the instruction decoder.
- Steps the datapath through DECODE/EXEC/MEM/WB, gating data-memory access, register-file write and PC update from the decoder's RegWr/MemWr/MemtoReg flags.
- Halts on illegal opcode, ECALL/EBREAK or misaligned next PC.

---
 rtl/rv32_multicycle_seq.sv | 167 ++++++++++++++++
 tb/tb_rv32_multicycle_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_multicycle_seq.sv
// rv32_multicycle_seq: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Gates memory, register-file write and PC update; halts on illegal/system/misaligned.
module rv32_multicycle_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   input  logic        RegWr,
   input  logic        MemWr,
   input  logic        MemtoReg,
   input  logic [31:0] next_pc,
   output logic [31:0] pc,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        rf_we,
   output logic        retire,
   output logic [31:0] instret,
   output logic        halted,
   output logic [1:0]  halt_cause
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [1:0] C_ILLEGAL  = 2'd1;
   localparam logic [1:0] C_SYSTEM   = 2'd2;
   localparam logic [1:0] C_MISALIGN = 2'd3;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_instret;
   logic [1:0]  r_cause;

   logic [6:0]  w_opcode;
   logic        w_legal;
   logic        w_system;
   logic        w_misalign;
   logic        w_in_fetch;
   logic        w_in_mem;
   logic        w_in_wb;
   logic        w_st_done;
   logic        w_commit;

   assign w_opcode = r_inst[6:0];

   // Classify the latched opcode into legal, system (ECALL/EBREAK) or illegal
   always_comb begin
      w_legal  = 1'b0;
      w_system = 1'b0;
      case (w_opcode)
         7'b0110011,
         7'b0010011,
         7'b0000011,
         7'b0100011,
         7'b1100011,
         7'b1101111,
         7'b1100111,
         7'b0010111,
         7'b0110111: w_legal  = 1'b1;
         7'b1110011: w_system = 1'b1;
         default:    w_legal  = 1'b0;
      endcase
   end

   assign w_misalign = |next_pc[1:0];
   assign w_in_fetch = (r_state == S_FETCH);
   assign w_in_mem   = (r_state == S_MEM);
   assign w_in_wb    = (r_state == S_WB);
   // A store commits from MEM on the completing data access
   assign w_st_done  = w_in_mem & dmem_ready & ~MemtoReg;
   assign w_commit   = (w_in_wb | w_st_done) & ~w_misalign;

   // Sequencer: state, PC, instruction register, retire counter, halt cause
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_PC;
         r_inst    <= 32'd0;
         r_instret <= 32'd0;
         r_cause   <= 2'd0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_ready) begin
                  r_inst  <= imem_rdata;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_system) begin
                  r_cause <= C_SYSTEM;
                  r_state <= S_HALT;
               end else if (!w_legal) begin
                  r_cause <= C_ILLEGAL;
                  r_state <= S_HALT;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (MemWr || MemtoReg) begin
                  r_state <= S_MEM;
               end else begin
                  r_state <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  if (MemtoReg) begin
                     r_state <= S_WB;
                  end else if (w_misalign) begin
                     r_cause <= C_MISALIGN;
                     r_state <= S_HALT;
                  end else begin
                     r_pc      <= next_pc;
                     r_instret <= r_instret + 32'd1;
                     r_state   <= S_FETCH;
                  end
               end
            end
            S_WB: begin
               if (w_misalign) begin
                  r_cause <= C_MISALIGN;
                  r_state <= S_HALT;
               end else begin
                  r_pc      <= next_pc;
                  r_instret <= r_instret + 32'd1;
                  r_state   <= S_FETCH;
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   // The async reset forces FETCH, so gate the fetch request while reset is held
   assign imem_req   = rst_n & w_in_fetch;
   assign imem_addr  = r_pc;
   assign inst       = r_inst;
   assign pc         = r_pc;
   assign dmem_req   = w_in_mem;
   assign dmem_we    = w_in_mem & MemWr;
   assign rf_we      = w_in_wb & RegWr & ~w_misalign;
   assign retire     = w_commit;
   assign instret    = r_instret;
   assign halted     = (r_state == S_HALT);
   assign halt_cause = r_cause;

endmodule

// File: tb/tb_rv32_multicycle_seq.sv
// tb_rv32_multicycle_seq: directed vector table plus hand sequences
// for halts, counter wrap and reset during a data access.
module tb_rv32_multicycle_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        RegWr;
   logic        MemWr;
   logic        MemtoReg;
   logic [31:0] next_pc;
   logic [31:0] pc;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ready;
   logic        rf_we;
   logic        retire;
   logic [31:0] instret;
   logic        halted;
   logic [1:0]  halt_cause;

   always #5 clk = ~clk;

   rv32_multicycle_seq #(.RESET_PC(32'h100)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .inst(inst), .RegWr(RegWr), .MemWr(MemWr),
      .MemtoReg(MemtoReg), .next_pc(next_pc), .pc(pc),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_ready(dmem_ready), .rf_we(rf_we),
      .retire(retire), .instret(instret),
      .halted(halted), .halt_cause(halt_cause)
   );

   typedef struct {
      logic [31:0] inst;
      logic        rw;
      logic        mw;
      logic        m2r;
      logic [31:0] npc;
      int          iw;
      int          dw;
      int          cyc;
      int          rfw;
      int          dreq;
      int          dwe;
      logic        ret;
      logic [1:0]  cause;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   logic [31:0] pc_exp;
   logic [31:0] instret_exp;
   logic [31:0] ir_exp;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [31:0] i, input logic rw, input logic mw,
      input logic m2r, input logic [31:0] npc,
      input int iw, input int dw, input int cyc, input int rfw,
      input int dreq, input int dwe, input logic ret,
      input logic [1:0] cause);
      vec_t v;
      v.inst = i;   v.rw = rw;   v.mw = mw;   v.m2r = m2r;
      v.npc = npc;  v.iw = iw;   v.dw = dw;   v.cyc = cyc;
      v.rfw = rfw;  v.dreq = dreq; v.dwe = dwe;
      v.ret = ret;  v.cause = cause;
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      RegWr = 1'b0;
      MemWr = 1'b0;
      MemtoReg = 1'b0;
      next_pc = 32'd0;
      imem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst retire", {31'd0, retire}, 32'd0);
      chk("rst pc", pc, 32'h100);
      chk("rst instret", instret, 32'd0);
      chk("rst inst", inst, 32'd0);
      chk("rst halted", {31'd0, halted}, 32'd0);
      chk("rst cause", {30'd0, halt_cause}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      pc_exp = 32'h100;
      instret_exp = 32'd0;
      ir_exp = 32'd0;
   endtask

   task automatic run(input vec_t v, input string nm);
      int cyc = 0;
      int rfw = 0;
      int dreq = 0;
      int dwe = 0;
      int both = 0;
      int abad = 0;
      int ichg = 0;
      int ic = 0;
      int dc = 0;
      int ret_cyc = 0;
      int act;
      imem_rdata = v.inst;
      RegWr = v.rw;
      MemWr = v.mw;
      MemtoReg = v.m2r;
      next_pc = v.npc;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (halted) break;
         cyc++;
         imem_ready = imem_req && (ic == v.iw);
         if (imem_req) ic++;
         dmem_ready = dmem_req && (dc == v.dw);
         if (dmem_req) dc++;
         #1;
         if (imem_req && dmem_req) both++;
         if (imem_req && imem_addr !== pc_exp) abad++;
         if (imem_req && inst !== ir_exp) ichg++;
         if (dmem_req) dreq++;
         if (dmem_req && dmem_we) dwe++;
         if (rf_we) rfw++;
         if (retire) begin
            ret_cyc = cyc;
            break;
         end
      end
      chk({nm, " cycles"}, cyc, v.cyc);
      chk({nm, " rf_we"}, rfw, v.rfw);
      chk({nm, " dmem_req"}, dreq, v.dreq);
      chk({nm, " dmem_we"}, dwe, v.dwe);
      chk({nm, " retire"}, {31'd0, ret_cyc != 0}, {31'd0, v.ret});
      chk({nm, " req overlap"}, both, 0);
      chk({nm, " fetch addr"}, abad, 0);
      chk({nm, " ir early"}, ichg, 0);
      if (ret_cyc != 0) begin
         @(posedge clk);
         #1;
         pc_exp = v.npc;
         instret_exp = instret_exp + 32'd1;
      end
      ir_exp = v.inst;
      chk({nm, " pc"}, pc, pc_exp);
      chk({nm, " instret"}, instret, instret_exp);
      chk({nm, " inst"}, inst, v.inst);
      chk({nm, " halted"}, {31'd0, halted}, {31'd0, v.cause != 2'd0});
      chk({nm, " cause"}, {30'd0, halt_cause}, {30'd0, v.cause});
      if (v.cause != 2'd0) begin
         act = 0;
         imem_ready = 1'b1;
         dmem_ready = 1'b1;
         repeat (4) begin
            @(negedge clk);
            #1;
            if (imem_req || dmem_req || rf_we || retire || !halted) act++;
         end
         chk({nm, " halt quiet"}, act, 0);
         chk({nm, " halt pc"}, pc, pc_exp);
      end
   endtask

   vec_t tbl[9];
   vec_t hv;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // inst, rw, mw, m2r, npc, iw, dw, cyc, rfw, dreq, dwe, ret, cause
      tbl[0] = mk(32'h00500093, 1, 0, 0, 32'h104, 0, 0, 4, 1, 0, 0, 1, 0);
      tbl[1] = mk(32'h00A00113, 1, 0, 0, 32'h108, 3, 0, 7, 1, 0, 0, 1, 0);
      tbl[2] = mk(32'h0000A183, 1, 0, 1, 32'h10C, 0, 2, 7, 1, 3, 0, 1, 0);
      tbl[3] = mk(32'h0030A023, 0, 1, 0, 32'h110, 0, 0, 4, 0, 1, 1, 1, 0);
      tbl[4] = mk(32'h00000463, 0, 0, 0, 32'h118, 0, 0, 4, 0, 0, 0, 1, 0);
      tbl[5] = mk(32'h008000EF, 1, 0, 0, 32'h200, 0, 0, 4, 1, 0, 0, 1, 0);
      tbl[6] = mk(32'h123450B7, 1, 0, 0, 32'h204, 1, 0, 5, 1, 0, 0, 1, 0);
      tbl[7] = mk(32'h0030A023, 0, 1, 0, 32'h208, 0, 1, 5, 0, 2, 2, 1, 0);
      tbl[8] = mk(32'h0000A183, 1, 0, 1, 32'h20C, 0, 0, 5, 1, 1, 0, 1, 0);

      do_reset();
      for (int i = 0; i < 9; i++) begin
         run(tbl[i], $sformatf("vec%0d", i));
      end

      // illegal opcode
      do_reset();
      hv = mk(32'h0000007F, 0, 0, 0, 32'h104, 0, 0, 2, 0, 0, 0, 0, 1);
      run(hv, "illegal");

      // ECALL
      do_reset();
      hv = mk(32'h00000073, 0, 0, 0, 32'h104, 0, 0, 2, 0, 0, 0, 0, 2);
      run(hv, "ecall");

      // misaligned jalr target with RegWr set: no write, no retire
      do_reset();
      hv = mk(32'h000080E7, 1, 0, 0, 32'h102, 0, 0, 4, 0, 0, 0, 0, 3);
      run(hv, "misalign jalr");

      // misaligned branch target
      do_reset();
      hv = mk(32'h00000463, 0, 0, 0, 32'h102, 1, 0, 5, 0, 0, 0, 0, 3);
      run(hv, "misalign br");

      // retire counter wraps to zero
      do_reset();
      force dut.r_instret = 32'hFFFF_FFFF;
      #1;
      release dut.r_instret;
      instret_exp = 32'hFFFF_FFFF;
      hv = mk(32'h00500093, 1, 0, 0, 32'h104, 0, 0, 4, 1, 0, 0, 1, 0);
      run(hv, "wrap");
      chk("wrap zero", instret, 32'd0);

      // reset while a load waits in MEM
      do_reset();
      imem_rdata = 32'h0000A183;
      MemtoReg = 1'b1;
      RegWr = 1'b1;
      next_pc = 32'h104;
      imem_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         if (dmem_req) break;
      end
      chk("midmem reached", {31'd0, dmem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midmem dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("midmem imem_req", {31'd0, imem_req}, 32'd0);
      chk("midmem inst", inst, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("midmem refetch", {31'd0, imem_req}, 32'd1);
      chk("midmem addr", imem_addr, 32'h100);
      chk("midmem dmem idle", {31'd0, dmem_req}, 32'd0);
      chk("midmem instret", instret, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
